// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the rv32i_core slice.
//   - RV32I major opcode constants
//   - alu_op_t: operation selector consumed by rv_alu
//   - DMEM_BASE: upper address half-word that selects the data RAM
//   - alu_decode(): maps funct3 plus the funct7 "alternate" bit to an ALU op
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // addr[31:16] must equal this for a load/store to reach the data RAM
  localparam logic [15:0] DMEM_BASE = 16'h0001;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } alu_op_t;

  // alt is instr[30]; callers only raise it where it is meaningful
  // (SUB/SRA for register ops, SRAI for immediate ops).
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'd0:    op = alt ? SUB : ADD;
      3'd1:    op = SLL;
      3'd2:    op = SLT;
      3'd3:    op = SLTU;
      3'd4:    op = XOR;
      3'd5:    op = alt ? SRA : SRL;
      3'd6:    op = OR;
      default: op = AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_alu.sv
// rv_alu: purely combinational 32-bit integer ALU.
//   a, b : operands
//   op   : operation select (alu_op_t)
//   y    : result; shifts use b[4:0], SLT/SLTU return 0 or 1
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      SLL:     y = a << b[4:0];
      SLT:     y = {31'b0, $signed(a) < $signed(b)};
      SLTU:    y = {31'b0, a < b};
      XOR:     y = a ^ b;
      SRL:     y = a >> b[4:0];
      SRA:     y = $unsigned($signed(a) >>> b[4:0]);
      OR:      y = a | b;
      AND:     y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core, one instruction retires per rising edge.
//   i_clk   : sole clock
//   i_reset : asynchronous active-high reset (pc, regs, halted; dmem is kept)
// Internal state of interest: pc, regs[0:31], halted, imem (ROM, filled by
// the surrounding environment), dmem (RAM at 0x0001_xxxx).
// The core halts permanently (until reset) on ECALL/EBREAK, illegal encodings,
// misaligned LH/LW/SH/SW, or a taken control transfer whose target has bit1 set.
// The halting instruction has no architectural side effect.
module rv32i_core
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 1024,
  parameter int          DMEM_WORDS   = 1024
) (
  input logic i_clk,
  input logic i_reset
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic        halted;

  logic [31:0] instr, pc_plus4;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr    = imem[pc[IW+1:2]];
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign f7       = instr[31:25];
  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // ALU operand select lives apart from the main decode so the decode can
  // consume alu_y (memory address, JALR target) without a comb loop.
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;

  always_comb begin
    alu_op = ADD;
    alu_b  = rs2_val;
    case (opcode)
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_decode(f3, (f3 == 3'd5) && f7[5]);
      end
      OP_REG:            alu_op = alu_decode(f3, f7[5]);
      OP_LOAD, OP_JALR:  alu_b  = imm_i;
      OP_STORE:          alu_b  = imm_s;
      default: ;
    endcase
  end

  rv_alu u_alu (.a(rs1_val), .b(alu_b), .op(alu_op), .y(alu_y));

  // Data memory read path; addresses outside the RAM window read as zero.
  logic        dmem_hit;
  logic [31:0] mem_word, ld_shift;

  assign dmem_hit = (alu_y[31:16] == DMEM_BASE);
  assign mem_word = dmem_hit ? dmem[alu_y[DW+1:2]] : '0;
  assign ld_shift = mem_word >> {alu_y[1:0], 3'b000};

  logic        wb_en, st_en, bad, taken;
  logic [31:0] wb_data, next_pc, st_data;
  logic [3:0]  st_be;
  logic        br_eq, br_lt, br_ltu;

  assign br_eq  = (rs1_val == rs2_val);
  assign br_lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign br_ltu = (rs1_val < rs2_val);

  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_y;
    next_pc = pc_plus4;
    st_en   = 1'b0;
    st_be   = 4'b0000;
    st_data = rs2_val;
    bad     = 1'b0;
    taken   = 1'b0;
    case (opcode)
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
        bad     = next_pc[1];
      end
      OP_JALR: begin
        // Target comes from the pre-edge rs1 value, so rd==rs1 is safe.
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = {alu_y[31:1], 1'b0};
        bad     = next_pc[1] || (f3 != 3'd0);
      end
      OP_BRANCH: begin
        case (f3)
          3'd0:    taken = br_eq;
          3'd1:    taken = !br_eq;
          3'd4:    taken = br_lt;
          3'd5:    taken = !br_lt;
          3'd6:    taken = br_ltu;
          3'd7:    taken = !br_ltu;
          default: bad   = 1'b1;
        endcase
        if (taken) begin
          next_pc = pc + imm_b;
          bad     = next_pc[1];
        end
      end
      OP_LOAD: begin
        wb_en = 1'b1;
        case (f3)
          3'd0: wb_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
          3'd1: begin
            wb_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            bad     = alu_y[0];
          end
          3'd2: begin
            wb_data = ld_shift;
            bad     = |alu_y[1:0];
          end
          3'd4: wb_data = {24'b0, ld_shift[7:0]};
          3'd5: begin
            wb_data = {16'b0, ld_shift[15:0]};
            bad     = alu_y[0];
          end
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        st_en = 1'b1;
        case (f3)
          3'd0: begin
            st_be   = 4'b0001 << alu_y[1:0];
            st_data = {4{rs2_val[7:0]}};
          end
          3'd1: begin
            st_be   = alu_y[1] ? 4'b1100 : 4'b0011;
            st_data = {2{rs2_val[15:0]}};
            bad     = alu_y[0];
          end
          3'd2: begin
            st_be = 4'b1111;
            bad   = |alu_y[1:0];
          end
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        wb_en = 1'b1;
        if ((f3 == 3'd1 && f7 != 7'h00) ||
            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
          bad = 1'b1;
      end
      OP_REG: begin
        wb_en = 1'b1;
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
          bad = 1'b1;
      end
      OP_FENCE:  bad = (f3 != 3'd0);
      OP_SYSTEM: bad = 1'b1;
      default:   bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc     <= RESET_VECTOR;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (bad) begin
        halted <= 1'b1;
      end else begin
        pc <= next_pc;
        if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
      end
    end
  end

  // Data RAM has no reset; it keeps its contents across core resets.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !halted && !bad && st_en && dmem_hit) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem[alu_y[DW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs for rv32i_core. Each program ends in a
// halt; expectations (probe selector + value) are queued when the program is
// loaded and a monitor pops and compares them once the core reports halted.
module tb_rv32i_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv32i_core #(
    .RESET_VECTOR(32'h0000_0000),
    .IMEM_WORDS  (1024),
    .DMEM_WORDS  (1024)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst)
  );

  // Probe selectors: 0..31 regs, 100 pc, 101 halted, 200+k dmem word k
  localparam int SEL_PC     = 100;
  localparam int SEL_HALTED = 101;
  localparam int SEL_DMEM   = 200;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] probe(input int sel);
    if (sel < 32)               return dut.regs[sel];
    else if (sel == SEL_PC)     return dut.pc;
    else if (sel == SEL_HALTED) return {31'b0, dut.halted};
    else                        return dut.dmem[sel - SEL_DMEM];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, required %08h", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endtask

  // Hold reset and fill the ROM with ECALL so a runaway program halts.
  task automatic start_load();
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0073;
  endtask

  task automatic put(input int word_idx, input logic [31:0] w);
    dut.imem[word_idx] = w;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d checks still pending, required 0", tag, exp_q.size());
      exp_q.delete();
      sel_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic release_and_drain(input string tag);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(tag);
  endtask

  // Monitor: the halted flag is the core's "result ready" indication.
  initial begin
    logic [31:0] e;
    int          s;
    string       t;
    forever begin
      @(negedge clk);
      if (!rst && dut.halted && exp_q.size() > 0) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          s = sel_q.pop_front();
          t = tag_q.pop_front();
          check(t, probe(s), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] reg_or;

    // ALU program, x0 write, ECALL halt
    start_load();
    put(0, 32'hFFF0_0093);  // addi x1,x0,-1
    put(1, 32'h01C0_D113);  // srli x2,x1,28
    put(2, 32'h41C0_D193);  // srai x3,x1,28
    put(3, 32'h0010_3233);  // sltu x4,x0,x1
    put(4, 32'h0070_0013);  // addi x0,x0,7
    put(5, 32'h4010_05B3);  // sub  x11,x0,x1
    put(6, 32'h0000_0073);  // ecall
    expect_val("alu_x1", 1, 32'hFFFF_FFFF);
    expect_val("alu_x2", 2, 32'h0000_000F);
    expect_val("alu_x3", 3, 32'hFFFF_FFFF);
    expect_val("alu_x4", 4, 32'h0000_0001);
    expect_val("x0_zero", 0, 32'h0000_0000);
    expect_val("alu_sub", 11, 32'h0000_0001);
    expect_val("ecall_pc", SEL_PC, 32'h0000_0018);
    expect_val("ecall_halted", SEL_HALTED, 32'h1);
    release_and_drain("alu");
    repeat (10) @(negedge clk);
    expect_val("freeze_pc", SEL_PC, 32'h0000_0018);
    expect_val("freeze_halted", SEL_HALTED, 32'h1);
    wait_drain("freeze");

    // Memory program: byte/half/word access, outside-window load
    start_load();
    put(0,  32'h0001_02B7);  // lui  x5,0x10
    put(1,  32'h0002_A023);  // sw   x0,0(x5)
    put(2,  32'h0002_A223);  // sw   x0,4(x5)
    put(3,  32'h0800_0313);  // addi x6,x0,0x80
    put(4,  32'h0062_80A3);  // sb   x6,1(x5)
    put(5,  32'h0012_8383);  // lb   x7,1(x5)
    put(6,  32'h0012_C403);  // lbu  x8,1(x5)
    put(7,  32'h0002_A483);  // lw   x9,0(x5)
    put(8,  32'hFFE0_0613);  // addi x12,x0,-2
    put(9,  32'h00C2_9323);  // sh   x12,6(x5)
    put(10, 32'h0062_9683);  // lh   x13,6(x5)
    put(11, 32'h0062_D703);  // lhu  x14,6(x5)
    put(12, 32'h0090_0793);  // addi x15,x0,9
    put(13, 32'h0000_2783);  // lw   x15,0(x0)  outside the RAM window
    put(14, 32'h0000_0073);  // ecall
    expect_val("lb_sext", 7, 32'hFFFF_FF80);
    expect_val("lbu_zext", 8, 32'h0000_0080);
    expect_val("lw_word", 9, 32'h0000_8000);
    expect_val("lh_sext", 13, 32'hFFFF_FFFE);
    expect_val("lhu_zext", 14, 32'h0000_FFFE);
    expect_val("lw_outside", 15, 32'h0000_0000);
    expect_val("dmem_w0", SEL_DMEM + 0, 32'h0000_8000);
    expect_val("dmem_w1", SEL_DMEM + 1, 32'hFFFE_0000);
    expect_val("mem_pc", SEL_PC, 32'h0000_0038);
    release_and_drain("mem");

    // Control program; first run is cut short by an asynchronous reset
    start_load();
    put(0, 32'h0050_0593);  // addi x11,x0,5
    put(1, 32'h0015_0513);  // addi x10,x10,1
    put(2, 32'hFEB5_1EE3);  // bne  x10,x11,-4
    put(3, 32'h0000_0013);  // nop
    put(4, 32'h0000_0013);
    put(5, 32'h0000_0013);
    put(6, 32'h0000_0013);
    put(7, 32'h0000_0013);
    put(8, 32'h0080_00EF);  // 0x20: jal x1,+8
    put(9, 32'h0010_0A13);  // 0x24: addi x20,x0,1 (skipped)
    put(10, 32'h0000_0073); // 0x28: ecall
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_x11", dut.regs[11], 32'h0000_0005);
    #2;
    rst = 1'b1;
    #1;
    check("reset_pc", dut.pc, 32'h0000_0000);
    reg_or = '0;
    for (int i = 0; i < 32; i++) reg_or = reg_or | dut.regs[i];
    check("reset_regs", reg_or, 32'h0000_0000);
    check("reset_halted", {31'b0, dut.halted}, 32'h0);
    check("reset_dmem_w0", dut.dmem[0], 32'h0000_8000);
    check("reset_dmem_w1", dut.dmem[1], 32'hFFFE_0000);
    expect_val("loop_x10", 10, 32'h0000_0005);
    expect_val("loop_x11", 11, 32'h0000_0005);
    expect_val("jal_link", 1, 32'h0000_0024);
    expect_val("jal_skip", 20, 32'h0000_0000);
    expect_val("ctrl_pc", SEL_PC, 32'h0000_0028);
    release_and_drain("ctrl");

    // Misaligned LW halts without writing rd
    start_load();
    put(0, 32'h0001_02B7);  // lui  x5,0x10
    put(1, 32'h0030_0493);  // addi x9,x0,3
    put(2, 32'h0022_A483);  // lw   x9,2(x5)
    expect_val("mis_halted", SEL_HALTED, 32'h1);
    expect_val("mis_pc", SEL_PC, 32'h0000_0008);
    expect_val("mis_rd", 9, 32'h0000_0003);
    release_and_drain("mis_lw");

    // JALR with rd==rs1
    start_load();
    put(0, 32'h00C0_0093);  // addi x1,x0,12
    put(1, 32'h0000_80E7);  // jalr x1,0(x1)
    put(2, 32'h0010_0A93);  // addi x21,x0,1 (skipped)
    expect_val("jalr_link", 1, 32'h0000_0008);
    expect_val("jalr_pc", SEL_PC, 32'h0000_000C);
    expect_val("jalr_skip", 21, 32'h0000_0000);
    release_and_drain("jalr");

    // Jump target with bit1 set halts and writes no link
    start_load();
    put(0, 32'h0060_00EF);  // jal x1,+6
    expect_val("badjmp_halted", SEL_HALTED, 32'h1);
    expect_val("badjmp_pc", SEL_PC, 32'h0000_0000);
    expect_val("badjmp_link", 1, 32'h0000_0000);
    release_and_drain("badjmp");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
